// File: rtl/mac_axil_cfg_master.sv
// AXI4-Lite initiator for the TEMAC management port: runs a fixed init
// sequence after reset, then serves single read/write commands.
module mac_axil_cfg_master #(
  parameter logic [31:0] SPEED_WORD     = 32'h8000_0000,
  parameter logic [31:0] RX_CFG_WORD    = 32'h1000_0000,
  parameter logic [31:0] TX_CFG_WORD    = 32'h1000_0000,
  parameter logic [11:0] VERSION_ADDR   = 12'h4F8,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [11:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        init_done,
  output logic        init_error,
  output logic        timeout_flag,
  output logic [31:0] mac_version,
  output logic [11:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [11:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);
  typedef enum logic [3:0] {
    INIT_W0, INIT_W1, INIT_W2, INIT_RD, IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA
  } state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

  state_t      state_q, ret_q;
  logic [11:0] awaddr_q, araddr_q;
  logic [31:0] wdata_q, rsp_rdata_q, mac_version_q;
  logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic        aw_done_q, w_done_q;
  logic        rsp_valid_q, init_done_q, init_error_q, tmo_flag_q;
  logic [1:0]  rsp_resp_q;
  logic [15:0] tmo_q;

  logic [11:0] tbl_addr;
  logic [31:0] tbl_data;
  state_t      tbl_ret;
  logic        aw_hs, w_hs, waiting, fin_hs;
  logic [1:0]  fin_resp;

  always_comb begin
    tbl_addr = 12'h410;
    tbl_data = SPEED_WORD;
    tbl_ret  = INIT_W1;
    case (state_q)
      INIT_W1: begin tbl_addr = 12'h404; tbl_data = RX_CFG_WORD; tbl_ret = INIT_W2; end
      INIT_W2: begin tbl_addr = 12'h408; tbl_data = TX_CFG_WORD; tbl_ret = INIT_RD; end
      default: ;
    endcase
  end

  assign aw_hs    = awvalid_q && m_axi_awready;
  assign w_hs     = wvalid_q && m_axi_wready;
  assign waiting  = (state_q == WR_ADDR) || (state_q == WR_RESP) ||
                    (state_q == RD_ADDR) || (state_q == RD_DATA);
  assign fin_hs   = ((state_q == WR_RESP) && m_axi_bvalid) ||
                    ((state_q == RD_DATA) && m_axi_rvalid);
  assign fin_resp = (state_q == RD_DATA) ? m_axi_rresp : m_axi_bresp;

  assign cmd_ready = (state_q == IDLE) && init_done_q;

  always_ff @(posedge s_axi_aclk or posedge s_axi_reset) begin
    if (s_axi_reset) begin
      state_q       <= INIT_W0;
      ret_q         <= INIT_W0;
      awaddr_q      <= '0;
      araddr_q      <= '0;
      wdata_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      init_done_q   <= 1'b0;
      init_error_q  <= 1'b0;
      tmo_flag_q    <= 1'b0;
      mac_version_q <= '0;
      tmo_q         <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      // Counter saturates at the limit; later transition assignments clear it.
      if (waiting && tmo_q != TMO) tmo_q <= tmo_q + 16'd1;
      if (tmo_q == TMO) tmo_flag_q <= 1'b1;

      case (state_q)
        INIT_W0, INIT_W1, INIT_W2: begin
          awaddr_q  <= tbl_addr;
          wdata_q   <= tbl_data;
          ret_q     <= tbl_ret;
          awvalid_q <= 1'b1;
          wvalid_q  <= 1'b1;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          state_q   <= WR_ADDR;
          tmo_q     <= '0;
        end
        INIT_RD: begin
          araddr_q  <= VERSION_ADDR;
          arvalid_q <= 1'b1;
          ret_q     <= IDLE;
          state_q   <= RD_ADDR;
          tmo_q     <= '0;
        end
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            ret_q <= IDLE;
            tmo_q <= '0;
            if (cmd_write) begin
              awaddr_q  <= cmd_addr;
              wdata_q   <= cmd_wdata;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= WR_ADDR;
            end else begin
              araddr_q  <= cmd_addr;
              arvalid_q <= 1'b1;
              state_q   <= RD_ADDR;
            end
          end
        end
        WR_ADDR: begin
          if (aw_hs) begin awvalid_q <= 1'b0; aw_done_q <= 1'b1; end
          if (w_hs)  begin wvalid_q  <= 1'b0; w_done_q  <= 1'b1; end
          if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
            tmo_q    <= '0;
          end
        end
        WR_RESP: if (m_axi_bvalid) bready_q <= 1'b0;
        RD_ADDR: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
            tmo_q     <= '0;
          end
        end
        RD_DATA: if (m_axi_rvalid) rready_q <= 1'b0;
        default: state_q <= IDLE;
      endcase

      // Completion of B or R beat: init bookkeeping or a command response.
      if (fin_hs) begin
        state_q <= ret_q;
        tmo_q   <= '0;
        if (!init_done_q) begin
          if (fin_resp != 2'b00) init_error_q <= 1'b1;
          if (state_q == RD_DATA) begin
            mac_version_q <= m_axi_rdata;
            init_done_q   <= 1'b1;
          end
        end else begin
          rsp_valid_q <= 1'b1;
          rsp_resp_q  <= fin_resp;
          rsp_rdata_q <= (state_q == RD_DATA) ? m_axi_rdata : 32'h0;
        end
      end
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign init_done     = init_done_q;
  assign init_error    = init_error_q;
  assign timeout_flag  = tmo_flag_q;
  assign mac_version   = mac_version_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
endmodule

// File: tb/tb_mac_axil_cfg_master.sv
// Directed bench for mac_axil_cfg_master with a small configurable AXI-Lite slave.
module tb_mac_axil_cfg_master;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [11:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid, init_done, init_error, timeout_flag;
  logic [31:0] rsp_rdata, mac_version;
  logic [1:0]  rsp_resp;
  logic [11:0] awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  mac_axil_cfg_master dut (
    .s_axi_aclk(clk), .s_axi_reset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .init_done(init_done), .init_error(init_error), .timeout_flag(timeout_flag),
    .mac_version(mac_version),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  int vec = 0, errs = 0;

  // Slave model knobs and logs
  int          aw_lat = 0, w_lat = 0;
  bit          ar_stall = 0;
  logic [11:0] err_addr = 12'hFFF;
  logic [31:0] version = 32'h0901_0000;
  int          awc, wc, stab_viol = 0;
  logic        got_aw, got_w;
  logic [11:0] lat_aw;
  logic [31:0] lat_w;
  logic [31:0] mem [logic [11:0]];
  logic [11:0] wa_log [$];
  logic [31:0] wd_log [$];
  logic [11:0] ra_log [$];
  logic        aw_pend_q, w_pend_q, ar_pend_q;
  logic [11:0] awaddr_h, araddr_h;
  logic [31:0] wdata_h;

  assign awready = awvalid && (awc >= aw_lat);
  assign wready  = wvalid && (wc >= w_lat);
  assign arready = arvalid && !ar_stall;

  always @(posedge clk) begin
    if (rst) begin
      awc <= 0; wc <= 0; got_aw <= 0; got_w <= 0;
      bvalid <= 0; bresp <= 0; rvalid <= 0; rresp <= 0; rdata <= 0;
      aw_pend_q <= 0; w_pend_q <= 0; ar_pend_q <= 0;
    end else begin
      awc <= (awvalid && !awready) ? awc + 1 : 0;
      wc  <= (wvalid && !wready) ? wc + 1 : 0;
      if (awvalid && awready) begin got_aw <= 1; lat_aw <= awaddr; end
      if (wvalid && wready) begin got_w <= 1; lat_w <= wdata; end
      if (got_aw && got_w && !bvalid) begin
        bvalid <= 1;
        bresp  <= (lat_aw == err_addr) ? 2'b10 : 2'b00;
        mem[lat_aw] = lat_w;
        wa_log.push_back(lat_aw);
        wd_log.push_back(lat_w);
        got_aw <= 0; got_w <= 0;
      end
      if (bvalid && bready) bvalid <= 0;
      if (arvalid && arready) begin
        rvalid <= 1;
        rresp  <= 2'b00;
        rdata  <= (araddr == 12'h4F8) ? version : (mem.exists(araddr) ? mem[araddr] : 32'h0);
        ra_log.push_back(araddr);
      end
      if (rvalid && rready) rvalid <= 0;
      // Valid must not drop and payload must not move while a handshake is pending
      if (aw_pend_q && (!awvalid || awaddr != awaddr_h)) stab_viol <= stab_viol + 1;
      if (w_pend_q && (!wvalid || wdata != wdata_h)) stab_viol <= stab_viol + 1;
      if (ar_pend_q && (!arvalid || araddr != araddr_h)) stab_viol <= stab_viol + 1;
      aw_pend_q <= awvalid && !awready; awaddr_h <= awaddr;
      w_pend_q  <= wvalid && !wready;   wdata_h  <= wdata;
      ar_pend_q <= arvalid && !arready; araddr_h <= araddr;
    end
  end

  task automatic clear_logs();
    wa_log.delete(); wd_log.delete(); ra_log.delete();
  endtask

  task automatic wait_init(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (init_done) begin ok = 1; break; end
    end
  endtask

  task automatic wait_rsp(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; break; end
    end
  endtask

  task automatic issue_cmd(input bit wr, input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  task automatic test_reset();
    logic [7:0] outs;
    rst = 1;
    repeat (3) @(negedge clk);
    outs = {awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready, init_done};
    vec++; if (outs !== 8'h00) begin errs++; $display("FAIL reset_ctrl got %h want 00", outs); end
    vec++; if ({init_error, timeout_flag} !== 2'b00) begin errs++; $display("FAIL reset_flags got %b want 00", {init_error, timeout_flag}); end
    vec++; if (mac_version !== 32'h0) begin errs++; $display("FAIL reset_version got %h want 0", mac_version); end
  endtask

  task automatic test_init();
    bit ok;
    clear_logs();
    @(negedge clk) rst = 0;
    wait_init(200, ok);
    vec++; if (!ok) begin errs++; $display("FAIL init_done got 0 want 1"); end
    vec++; if (wa_log.size() != 3 || ra_log.size() != 1) begin
      errs++; $display("FAIL init_count got w=%0d r=%0d want w=3 r=1", wa_log.size(), ra_log.size()); end
    else begin
      vec++; if ({wa_log[0], wa_log[1], wa_log[2]} !== {12'h410, 12'h404, 12'h408}) begin
        errs++; $display("FAIL init_addrs got %h %h %h want 410 404 408", wa_log[0], wa_log[1], wa_log[2]); end
      vec++; if ({wd_log[0], wd_log[1], wd_log[2]} !== {32'h8000_0000, 32'h1000_0000, 32'h1000_0000}) begin
        errs++; $display("FAIL init_data got %h %h %h want 80000000 10000000 10000000", wd_log[0], wd_log[1], wd_log[2]); end
      vec++; if (ra_log[0] !== 12'h4F8) begin errs++; $display("FAIL init_rdaddr got %h want 4f8", ra_log[0]); end
    end
    vec++; if (mac_version !== 32'h0901_0000) begin errs++; $display("FAIL init_version got %h want 09010000", mac_version); end
    vec++; if (init_error !== 1'b0) begin errs++; $display("FAIL init_error got %b want 0", init_error); end
  endtask

  task automatic test_cmd();
    bit ok, busy;
    issue_cmd(1, 12'h708, 32'hDEAD_BEEF);
    @(negedge clk);
    busy = cmd_ready;
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL cmd_busy got %b want 0", busy); end
    wait_rsp(50, ok);
    vec++; if (!ok) begin errs++; $display("FAIL wr_rsp got none want pulse"); end
    vec++; if ({rsp_resp, rsp_rdata} !== 34'h0) begin errs++; $display("FAIL wr_rsp_fields got %b/%h want 00/0", rsp_resp, rsp_rdata); end
    vec++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL wr_rdy_at_rsp got %b want 1", cmd_ready); end
    @(negedge clk);
    vec++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rsp_one_cycle got %b want 0", rsp_valid); end
    issue_cmd(0, 12'h708, 32'h0);
    wait_rsp(50, ok);
    vec++; if (!ok || rsp_rdata !== 32'hDEAD_BEEF || rsp_resp !== 2'b00) begin
      errs++; $display("FAIL rd_rsp got ok=%0d %h/%b want DEADBEEF/00", ok, rsp_rdata, rsp_resp); end
  endtask

  task automatic test_timeout();
    bit ok;
    ar_stall = 1;
    issue_cmd(0, 12'h708, 32'h0);
    repeat (1000) @(negedge clk);
    vec++; if ({timeout_flag, arvalid} !== 2'b01) begin
      errs++; $display("FAIL tmo_early got flag=%b arvalid=%b want 0 1", timeout_flag, arvalid); end
    repeat (100) @(negedge clk);
    vec++; if ({timeout_flag, arvalid} !== 2'b11) begin
      errs++; $display("FAIL tmo_late got flag=%b arvalid=%b want 1 1", timeout_flag, arvalid); end
    ar_stall = 0;
    wait_rsp(20, ok);
    vec++; if (!ok || rsp_rdata !== 32'hDEAD_BEEF) begin
      errs++; $display("FAIL tmo_complete got ok=%0d %h want DEADBEEF", ok, rsp_rdata); end
    vec++; if (stab_viol != 0) begin errs++; $display("FAIL stability got %0d want 0", stab_viol); end
  endtask

  task automatic test_wready_delay();
    bit ok, seen;
    w_lat = 3;
    rst = 1; repeat (2) @(negedge clk);
    clear_logs();
    rst = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (awvalid && awready) begin seen = 1; break; end
    end
    @(negedge clk);
    vec++; if (!seen || {awvalid, wvalid} !== 2'b01) begin
      errs++; $display("FAIL aw_drop got seen=%0d aw=%b w=%b want 1 0 1", seen, awvalid, wvalid); end
    wait_init(300, ok);
    vec++; if (!ok || wa_log.size() != 3 || ra_log.size() != 1) begin
      errs++; $display("FAIL wdelay_beats got ok=%0d w=%0d r=%0d want 1 3 1", ok, wa_log.size(), ra_log.size()); end
    else begin
      vec++; if (wa_log[2] !== 12'h408 || wd_log[2] !== 32'h1000_0000) begin
        errs++; $display("FAIL wdelay_last got %h=%h want 408=10000000", wa_log[2], wd_log[2]); end
    end
    w_lat = 0;
  endtask

  task automatic test_init_error();
    bit ok;
    err_addr = 12'h404;
    rst = 1; repeat (2) @(negedge clk);
    clear_logs();
    rst = 0;
    wait_init(200, ok);
    vec++; if (!ok || init_error !== 1'b1) begin
      errs++; $display("FAIL init_err got done=%0d err=%b want 1 1", ok, init_error); end
    vec++; if (wa_log.size() != 3 || ra_log.size() != 1 || mac_version !== 32'h0901_0000) begin
      errs++; $display("FAIL init_err_rest got w=%0d r=%0d ver=%h want 3 1 09010000", wa_log.size(), ra_log.size(), mac_version); end
    err_addr = 12'hFFF;
  endtask

  task automatic test_reset_mid();
    bit ok, seen;
    rst = 1; repeat (2) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 20 && !awvalid; i++) @(negedge clk);
    #1 rst = 1;
    #1;
    vec++; if ({awvalid, wvalid, bready, arvalid, rready, init_done} !== 6'h0) begin
      errs++; $display("FAIL mid_reset got aw=%b w=%b b=%b ar=%b r=%b done=%b want all 0",
                       awvalid, wvalid, bready, arvalid, rready, init_done); end
    repeat (2) @(negedge clk);
    clear_logs();
    rst = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (awvalid && awready) begin seen = 1; break; end
    end
    vec++; if (!seen || awaddr !== 12'h410 || init_done !== 1'b0) begin
      errs++; $display("FAIL mid_restart got seen=%0d addr=%h done=%b want 1 410 0", seen, awaddr, init_done); end
    wait_init(200, ok);
    vec++; if (!ok || wa_log.size() != 3) begin
      errs++; $display("FAIL mid_finish got done=%0d w=%0d want 1 3", ok, wa_log.size()); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_cmd();
    test_timeout();
    test_wready_delay();
    test_init_error();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/mac_axil_cfg_master.md
Name: mac_axil_cfg_master

Overview:
- AXI4-Lite initiator that drives the Tri-Mode Ethernet MAC management slave port (12-bit address, 32-bit data).
- After reset it runs a fixed init sequence: speed, receiver config, transmitter config, then a version readback.
- It then serves single register read/write commands from a simple command/response port used by the switch control logic.
- Sits beside each MAC instance and connects to its s_axi_* port.

Parameters:
- SPEED_WORD, 32'h8000_0000, value written to 0x410 (speed config, 1 Gb/s).
- RX_CFG_WORD, 32'h1000_0000, value written to 0x404 (receiver config word 1, RX enable).
- TX_CFG_WORD, 32'h1000_0000, value written to 0x408 (transmitter config, TX enable).
- VERSION_ADDR, 12'h4F8, address read at the end of init.
- TIMEOUT_CYCLES, 1024, cycles per AXI phase before the timeout flag is set.

Ports:
- s_axi_aclk  in  1  sole clock.
- s_axi_reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  12  register address.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle response strobe; no backpressure.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP of the completed transaction.
- init_done  out  1  init sequence complete.
- init_error  out  1  sticky; any init response was not OKAY.
- timeout_flag  out  1  sticky; a phase exceeded TIMEOUT_CYCLES.
- mac_version  out  32  RDATA captured from VERSION_ADDR.
- m_axi_awaddr/awvalid/awready  out/out/in  12/1/1  write address channel.
- m_axi_wdata/wvalid/wready  out/out/in  32/1/1  write data channel.
- m_axi_bresp/bvalid/bready  in/in/out  2/1/1  write response channel.
- m_axi_araddr/arvalid/arready  out/out/in  12/1/1  read address channel.
- m_axi_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  read data channel.

Behaviour:
- Reset: every output is 0. FSM goes to INIT_W0. Sticky flags clear.
- Reset asserted mid-transaction: all valid/ready outputs drop immediately; init restarts after deassertion.
- States: INIT_W0, INIT_W1, INIT_W2, INIT_RD, IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA.
  - INIT_Wn/INIT_RD reuse the WR_*/RD_* sequencing with the table address and data. A return-to field selects the next init step or IDLE.
- Write phase:
  - awvalid and wvalid rise together, registered, in the cycle after entry.
  - Each deasserts independently the cycle after its own handshake. Address and data stay stable while valid.
  - Once both handshakes are done, go to WR_RESP with bready = 1.
  - On bvalid, capture bresp, drop bready, leave the state.
- Read phase:
  - arvalid is held until arready.
  - Then RD_DATA with rready = 1; on rvalid, capture rdata and rresp.
- Valid is never withdrawn before its handshake, including on timeout.
- Init completion:
  - After the INIT_RD data beat, mac_version <= rdata and init_done <= 1 (held until reset).
  - Any non-zero bresp or rresp during init sets init_error. The sequence still completes.
- Command port:
  - cmd_ready = (state == IDLE) && init_done.
  - An accepted command is registered (addr, data, dir) and AXI valids rise on the next cycle.
  - rsp_valid pulses one cycle after the B or R handshake. It carries rsp_resp; rsp_rdata = rdata for reads, 0 for writes.
  - cmd_ready returns in the same cycle as rsp_valid.
  - Only one transaction is outstanding at any time.
- Timeout:
  - A 16-bit counter clears on each state entry and increments while the current handshake is pending.
  - Reaching TIMEOUT_CYCLES sets timeout_flag; the counter saturates and the FSM keeps waiting.
- Simultaneous awready and wready in the same cycle: both complete; WR_RESP is entered next cycle.
- bvalid already high on WR_RESP entry: accepted in that first cycle.
- m_axi_awaddr/araddr hold their last value when idle. Only the valids are defined.

Test Plan:
- Release reset with a slave that has zero-wait ready and OKAY responses, VERSION = 32'h0901_0000 -> writes occur in order 0x410 = 8000_0000, 0x404 = 1000_0000, 0x408 = 1000_0000; then a read of 0x4F8; init_done = 1; mac_version = 32'h0901_0000; init_error = 0.
- Slave with wready 3 cycles after awready on each write -> awvalid falls 1 cycle after its handshake; wvalid held until its own handshake; no duplicate beats.
- After init, command write 0x708 = DEADBEEF, then command read 0x708 returning DEADBEEF -> two rsp_valid pulses; second has rsp_rdata = DEADBEEF, rsp_resp = 0; cmd_ready low between accept and response.
- Init write to 0x404 answered with bresp = 2'b10 -> init_error = 1; remaining init steps still run; init_done = 1.
- arready held low for 1100 cycles -> timeout_flag sets at cycle 1024; arvalid stays high; the read completes normally afterwards.
- Assert s_axi_reset while awvalid is high, then release -> valids are 0 during reset; init restarts with a write to 0x410; init_done = 0 until the sequence finishes.
